// File: rtl/audio_pkg.sv
// Shared definitions for the audio playout path.
// - Playback FSM state constants (FILL waits for enough samples, PLAY consumes
//   one sample per tick).
// - clog2_f: ceiling log2, used to size FIFO pointers.
// - midscale: the offset-binary code for silence at a given sample width.
package audio_pkg;

    localparam logic ST_FILL = 1'b0;
    localparam logic ST_PLAY = 1'b1;

    function automatic int clog2_f(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] midscale(input int w);
        return 32'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/pwm_dac.sv
// Free-running PWM generator for the DAC output.
// Ports:
//   clk     - system clock
//   reset   - asynchronous active-high reset (counter and output cleared)
//   duty_i  - duty code; high time = duty_i / 2^PWM_W, 0 gives constant low
//   pwm_o   - registered PWM output
module pwm_dac #(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PWM_W-1:0] duty_i,
    output logic             pwm_o
);

    logic [PWM_W-1:0] cnt_q;
    logic             pwm_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
            pwm_q <= 1'b0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            pwm_q <= (cnt_q < duty_i);
        end
    end

    assign pwm_o = pwm_q;

endmodule

// File: rtl/sample_playout_buffer.sv
// Sample playout buffer: a producer pushes samples into a FIFO with a
// valid/ready handshake; one sample is popped per sample-rate tick and drives
// a PWM DAC. The FSM primes the FIFO (FILL) before playing and falls back to
// FILL on underrun, so the playback rate is set by the tick alone.
// Ports:
//   clk, reset      - clock, asynchronous active-high reset
//   tick, enable    - sample-rate strobe; ticks are ignored while enable is 0
//   in_data/valid   - producer sample and its valid flag
//   in_ready        - FIFO not full (ignores a same-cycle pop)
//   sample_out      - sample being played (registered)
//   sample_strobe   - pulses high in the cycle sample_out takes a new sample
//   level           - FIFO occupancy 0..DEPTH
//   need_data       - level <= LOW_MARK, refill request to the producer
//   playing         - FSM is in PLAY
//   underrun_count  - saturating count of ticks that found the FIFO empty
//   pwm_out         - PWM rendering of sample_out
module sample_playout_buffer
    import audio_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int DEPTH      = 16,
    parameter int START_MARK = 8,
    parameter int LOW_MARK   = 4,
    parameter int PWM_W      = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        tick,
    input  logic                        enable,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [DATA_W-1:0]           sample_out,
    output logic                        sample_strobe,
    output logic [clog2_f(DEPTH):0]     level,
    output logic                        need_data,
    output logic                        playing,
    output logic [15:0]                 underrun_count,
    output logic                        pwm_out
);

    localparam int AW = clog2_f(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [DATA_W-1:0] SILENCE = DATA_W'(midscale(DATA_W));

    logic [DATA_W-1:0] mem [DEPTH];

    logic [AW-1:0]     wptr_q,   wptr_d;
    logic [AW-1:0]     rptr_q,   rptr_d;
    logic [LW-1:0]     level_q,  level_d;
    logic              state_q,  state_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              strobe_q, strobe_d;
    logic [15:0]       und_q,    und_d;

    logic full;
    logic empty;
    logic push;
    logic play_tick;
    logic pop;
    logic underrun;

    assign full      = (level_q == LW'(DEPTH));
    assign empty     = (level_q == '0);
    assign push      = in_valid && !full;
    assign play_tick = (state_q == ST_PLAY) && tick && enable;
    assign pop       = play_tick && !empty;
    assign underrun  = play_tick && empty;

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        state_d  = state_q;
        sample_d = sample_q;
        strobe_d = pop;
        und_d    = und_q;

        // Pointers wrap naturally because DEPTH is a power of two.
        if (push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d   = rptr_q + 1'b1;
            sample_d = mem[rptr_q];
        end
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase

        if (underrun && (und_q != 16'hFFFF)) begin
            und_d = und_q + 16'd1;
        end

        // The priming decision looks at the registered level, so PLAY
        // starts the cycle after the level reaches START_MARK.
        case (state_q)
            ST_FILL: if (level_q >= LW'(START_MARK)) state_d = ST_PLAY;
            default: if (underrun)                  state_d = ST_FILL;
        endcase
    end

    // Storage has no reset: stale words are never read because the level
    // and pointers are cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            state_q  <= ST_FILL;
            sample_q <= SILENCE;
            strobe_q <= 1'b0;
            und_q    <= '0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            state_q  <= state_d;
            sample_q <= sample_d;
            strobe_q <= strobe_d;
            und_q    <= und_d;
        end
    end

    pwm_dac #(
        .PWM_W (PWM_W)
    ) u_pwm (
        .clk    (clk),
        .reset  (reset),
        .duty_i (sample_q[DATA_W-1 -: PWM_W]),
        .pwm_o  (pwm_out)
    );

    assign in_ready       = !full;
    assign sample_out     = sample_q;
    assign sample_strobe  = strobe_q;
    assign level          = level_q;
    assign need_data      = (level_q <= LW'(LOW_MARK));
    assign playing        = (state_q == ST_PLAY);
    assign underrun_count = und_q;

endmodule

// File: tb/tb_sample_playout_buffer.sv
module tb_sample_playout_buffer;

    localparam int DATA_W     = 8;
    localparam int DEPTH      = 16;
    localparam int START_MARK = 8;
    localparam int LOW_MARK   = 4;
    localparam int PWM_W      = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        tick = 1'b0;
    logic        enable = 1'b1;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  sample_out;
    logic        sample_strobe;
    logic [4:0]  level;
    logic        need_data;
    logic        playing;
    logic [15:0] underrun_count;
    logic        pwm_out;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    sample_playout_buffer #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .START_MARK(START_MARK),
        .LOW_MARK(LOW_MARK), .PWM_W(PWM_W)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .enable(enable),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .sample_out(sample_out), .sample_strobe(sample_strobe),
        .level(level), .need_data(need_data), .playing(playing),
        .underrun_count(underrun_count), .pwm_out(pwm_out)
    );

    // Reference model: a queue of buffered samples plus play/hold flags.
    logic [7:0] m_q[$];
    bit         m_play;
    logic [7:0] m_sample;
    bit         m_strobe;
    int         m_und;

    task automatic model_reset();
        m_q.delete();
        m_play   = 0;
        m_sample = 8'h80;
        m_strobe = 0;
        m_und    = 0;
    endtask

    task automatic model_step(bit v, logic [7:0] d, bit t, bit e);
        int sz;
        bit go, popq, und, acc, nplay;
        sz    = m_q.size();
        go    = m_play && t && e;
        popq  = go && (sz > 0);
        und   = go && (sz == 0);
        acc   = v && (sz < DEPTH);
        nplay = m_play ? !und : (sz >= START_MARK);
        m_strobe = popq;
        if (popq) m_sample = m_q.pop_front();
        if (und && m_und < 65535) m_und++;
        if (acc) m_q.push_back(d);
        m_play = nplay;
    endtask

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step(bit v, logic [7:0] d, bit t, bit e);
        in_valid = v;
        in_data  = d;
        tick     = t;
        enable   = e;
        model_step(v, d, t, e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        tick     = 1'b0;
        enable   = 1'b1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        tick     = 1'b0;
        enable   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic check_model(string tag);
        chk({tag, "_level"},   32'(level),          32'(m_q.size()));
        chk({tag, "_sample"},  32'(sample_out),     32'(m_sample));
        chk({tag, "_strobe"},  32'(sample_strobe),  32'(m_strobe));
        chk({tag, "_playing"}, 32'(playing),        32'(m_play));
        chk({tag, "_ready"},   32'(in_ready),       32'(m_q.size() < DEPTH));
        chk({tag, "_need"},    32'(need_data),      32'(m_q.size() <= LOW_MARK));
        chk({tag, "_underrun"},32'(underrun_count), 32'(m_und));
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        bit         t;
        bit         e;
        int         lvl;
        bit         ply;
        logic [7:0] smp;
        bit         stb;
        bit         rdy;
    } vec_t;

    vec_t vecs[14];

    initial begin
        int strobes;
        int highs;
        bit ok;

        // Priming and first pops, one row per clock.
        vecs[0]  = '{1, 8'h10, 0, 1, 1, 0, 8'h80, 0, 1};
        vecs[1]  = '{1, 8'h11, 1, 1, 2, 0, 8'h80, 0, 1};
        vecs[2]  = '{1, 8'h12, 0, 1, 3, 0, 8'h80, 0, 1};
        vecs[3]  = '{1, 8'h13, 0, 1, 4, 0, 8'h80, 0, 1};
        vecs[4]  = '{1, 8'h14, 0, 1, 5, 0, 8'h80, 0, 1};
        vecs[5]  = '{1, 8'h15, 0, 1, 6, 0, 8'h80, 0, 1};
        vecs[6]  = '{1, 8'h16, 0, 1, 7, 0, 8'h80, 0, 1};
        vecs[7]  = '{1, 8'h17, 0, 1, 8, 0, 8'h80, 0, 1};
        vecs[8]  = '{0, 8'h00, 0, 1, 8, 1, 8'h80, 0, 1};
        vecs[9]  = '{0, 8'h00, 1, 1, 7, 1, 8'h10, 1, 1};
        vecs[10] = '{0, 8'h00, 0, 1, 7, 1, 8'h10, 0, 1};
        vecs[11] = '{1, 8'h18, 1, 1, 7, 1, 8'h11, 1, 1};
        vecs[12] = '{0, 8'h00, 1, 0, 7, 1, 8'h11, 0, 1};
        vecs[13] = '{0, 8'h00, 1, 1, 6, 1, 8'h12, 1, 1};

        do_reset();
        chk("rst_level",   32'(level), 0);
        chk("rst_sample",  32'(sample_out), 32'h80);
        chk("rst_strobe",  32'(sample_strobe), 0);
        chk("rst_playing", 32'(playing), 0);
        chk("rst_undr",    32'(underrun_count), 0);
        chk("rst_ready",   32'(in_ready), 1);
        chk("rst_need",    32'(need_data), 1);

        for (int i = 0; i < 14; i++) begin
            step(vecs[i].v, vecs[i].d, vecs[i].t, vecs[i].e);
            chk($sformatf("vec%0d_level", i),   32'(level),         32'(vecs[i].lvl));
            chk($sformatf("vec%0d_playing", i), 32'(playing),       32'(vecs[i].ply));
            chk($sformatf("vec%0d_sample", i),  32'(sample_out),    32'(vecs[i].smp));
            chk($sformatf("vec%0d_strobe", i),  32'(sample_strobe), 32'(vecs[i].stb));
            chk($sformatf("vec%0d_ready", i),   32'(in_ready),      32'(vecs[i].rdy));
        end

        // Ticks 100 clocks apart; each strobe one clock after its tick.
        do_reset();
        for (int i = 0; i < 8; i++) step(1, 8'(8'h10 + i), 0, 1);
        step(0, 0, 0, 1);
        strobes = 0;
        for (int k = 0; k < 3; k++) begin
            for (int j = 0; j < 99; j++) begin
                step(0, 0, 0, 1);
                strobes += int'(sample_strobe);
            end
            step(0, 0, 1, 1);
            chk("spaced_strobe", 32'(sample_strobe), 1);
            chk("spaced_sample", 32'(sample_out), 32'(8'h10 + k));
            strobes += int'(sample_strobe);
        end
        step(0, 0, 0, 1);
        strobes += int'(sample_strobe);
        chk("spaced_strobe_total", 32'(strobes), 3);
        chk("spaced_level", 32'(level), 5);

        // Fill to full, refused 17th word, push+pop while full.
        do_reset();
        for (int i = 0; i < 16; i++) step(1, 8'(8'h20 + i), 0, 1);
        chk("full_level", 32'(level), 16);
        chk("full_ready", 32'(in_ready), 0);
        step(1, 8'hEE, 0, 1);
        chk("full_reject_level", 32'(level), 16);
        chk("full_playing", 32'(playing), 1);
        step(1, 8'hEF, 1, 1);
        chk("full_poppush_level", 32'(level), 15);
        chk("full_poppush_sample", 32'(sample_out), 32'h20);
        ok = 1;
        for (int i = 1; i < 16; i++) begin
            step(0, 0, 1, 1);
            if (sample_out !== 8'(8'h20 + i)) ok = 0;
        end
        chk("drain_order_ok", 32'(ok), 1);
        chk("drain_level", 32'(level), 0);
        chk("drain_playing", 32'(playing), 1);

        // Underrun with a same-cycle push into the empty FIFO.
        step(1, 8'h55, 1, 1);
        chk("undr_count", 32'(underrun_count), 1);
        chk("undr_sample_hold", 32'(sample_out), 32'h2F);
        chk("undr_playing", 32'(playing), 0);
        chk("undr_level_kept", 32'(level), 1);
        for (int i = 0; i < 5; i++) step(1, 8'(i), 1, 1);
        chk("undr_fill_count", 32'(underrun_count), 1);
        chk("undr_fill_level", 32'(level), 6);
        chk("undr_fill_sample", 32'(sample_out), 32'h2F);

        // enable=0 ignores ticks; PWM duty at sample 0x40.
        do_reset();
        step(1, 8'h40, 0, 1);
        for (int i = 1; i < 11; i++) step(1, 8'(8'h40 + i), 0, 1);
        step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        chk("en_first_sample", 32'(sample_out), 32'h40);
        chk("en_first_level", 32'(level), 10);
        strobes = 0;
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 0);
            strobes += int'(sample_strobe);
        end
        chk("en0_strobes", 32'(strobes), 0);
        chk("en0_level", 32'(level), 10);
        chk("en0_sample", 32'(sample_out), 32'h40);
        highs = 0;
        for (int i = 0; i < 256; i++) begin
            step(0, 0, 0, 1);
            highs += int'(pwm_out);
        end
        chk("pwm_high_count", 32'(highs), 64);

        // Asynchronous reset between edges clears everything at once.
        step(0, 0, 1, 1);
        #2;
        reset = 1'b1;
        #1;
        chk("async_level", 32'(level), 0);
        chk("async_sample", 32'(sample_out), 32'h80);
        chk("async_strobe", 32'(sample_strobe), 0);
        chk("async_playing", 32'(playing), 0);
        chk("async_pwm", 32'(pwm_out), 0);
        chk("async_ready", 32'(in_ready), 1);
        chk("async_need", 32'(need_data), 1);
        do_reset();

        // Randomized traffic against the queue model, alternating
        // producer-heavy and consumer-heavy phases to force underruns.
        for (int ph = 0; ph < 8; ph++) begin
            for (int c = 0; c < 500; c++) begin
                bit v, t, e;
                v = (ph % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0);
                t = ($urandom_range(0, 3) == 0);
                e = ($urandom_range(0, 15) != 0);
                step(v, 8'($urandom), t, e);
                check_model("rand");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
